// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation-select encoding and its width.
package usr_pkg;

  localparam int USR_MODE_W = 2;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_t;

endpackage

// File: rtl/usr_cell.sv
// One register bit: hold / take upper neighbour / take lower neighbour / load, with registered complement.
// Latency one clk; no backpressure, en=0 freezes the bit.
module usr_cell
  import usr_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  usr_mode_t mode,
  input  logic      from_hi,
  input  logic      from_lo,
  input  logic      d,
  output logic      q,
  output logic      qb
);

  logic q_d;
  logic q_q;
  logic qb_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        USR_SHR:  q_d = from_hi;
        USR_SHL:  q_d = from_lo;
        USR_LOAD: q_d = d;
        default:  q_d = q_q;
      endcase
    end
  end

  // Complement is a second flop fed from the same next-state, so it can never diverge from q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q  <= 1'b0;
      qb_q <= 1'b1;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  assign q  = q_q;
  assign qb = qb_q;

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register (hold/shr/shl/load) with shift-frame counter; one clk latency, en=0 stalls all state.
// Optional rotate-on-shift when USR_ROTATE_EN is defined; otherwise rotate is ignored and si fills.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [USR_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]      d,
  input  logic                  si,
  input  logic                  rotate,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb,
  output logic                  so,
  output logic [CNT_W-1:0]      shift_cnt,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  usr_mode_t        mode_e;
  logic             fill_r;
  logic             fill_l;
  logic [WIDTH-1:0] shr_src;
  logic [WIDTH-1:0] shl_src;
  logic             shift_ev;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             frame_done_d;
  logic             frame_done_q;

  assign mode_e = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
  assign fill_r = rotate ? q[0]       : si;
  assign fill_l = rotate ? q[WIDTH-1] : si;
`else
  logic rotate_unused;
  assign rotate_unused = rotate;
  assign fill_r = si;
  assign fill_l = si;
`endif

  assign shr_src = {fill_r, q[WIDTH-1:1]};
  assign shl_src = {q[WIDTH-2:0], fill_l};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode_e),
      .from_hi (shr_src[i]),
      .from_lo (shl_src[i]),
      .d       (d[i]),
      .q       (q[i]),
      .qb      (qb[i])
    );
  end

  assign shift_ev = en && ((mode_e == USR_SHR) || (mode_e == USR_SHL));

  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (en && (mode_e == USR_LOAD)) begin
      cnt_d = '0;
    end else if (shift_ev) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // so previews the bit the next right/left shift will push out.
  assign so         = (mode_e == USR_SHR) ? q[0] : q[WIDTH-1];
  assign shift_cnt  = cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=4; rotate expectations follow USR_ROTATE_EN.
module tb_universal_shift_reg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] d;
  logic       si;
  logic       rotate;
  logic [3:0] q;
  logic [3:0] qb;
  logic       so;
  logic [2:0] shift_cnt;
  logic       frame_done;

  int n_vec;
  int n_err;

  universal_shift_reg #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .d          (d),
    .si         (si),
    .rotate     (rotate),
    .q          (q),
    .qb         (qb),
    .so         (so),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b11; d = 4'hF; si = 1'b1; rotate = 1'b0;
    tick();
    tick();
    n_vec++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q got=%b exp=0000", q); end
    n_vec++; if (qb !== 4'b1111) begin n_err++; $display("FAIL reset_qb got=%b exp=1111", qb); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_load();
    rst_n = 1'b1; en = 1'b1; mode = 2'b11; d = 4'b1011;
    tick();
    n_vec++; if (q !== 4'b1011) begin n_err++; $display("FAIL load_q got=%b exp=1011", q); end
    n_vec++; if (qb !== 4'b0100) begin n_err++; $display("FAIL load_qb got=%b exp=0100", qb); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL load_cnt got=%0d exp=0", shift_cnt); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL load_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_shift_right();
    logic [3:0] exp_q   [4] = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    logic       exp_so  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    mode = 2'b01; si = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (so !== exp_so[k]) begin n_err++; $display("FAIL shr_so[%0d] got=%b exp=%b", k, so, exp_so[k]); end
      tick();
      n_vec++; if (q !== exp_q[k]) begin n_err++; $display("FAIL shr_q[%0d] got=%b exp=%b", k, q, exp_q[k]); end
      n_vec++; if (qb !== ~exp_q[k]) begin n_err++; $display("FAIL shr_qb[%0d] got=%b exp=%b", k, qb, ~exp_q[k]); end
      n_vec++; if (shift_cnt !== exp_cnt[k]) begin n_err++; $display("FAIL shr_cnt[%0d] got=%0d exp=%0d", k, shift_cnt, exp_cnt[k]); end
      n_vec++; if (frame_done !== (k == 3)) begin n_err++; $display("FAIL shr_fd[%0d] got=%b exp=%b", k, frame_done, (k == 3)); end
    end
  endtask

  task automatic test_shift_left();
    logic [3:0] exp_q [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    mode = 2'b10; si = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (so !== q[3]) begin n_err++; $display("FAIL shl_so[%0d] got=%b exp=%b", k, so, (k == 3)); end
      tick();
      n_vec++; if (q !== exp_q[k]) begin n_err++; $display("FAIL shl_q[%0d] got=%b exp=%b", k, q, exp_q[k]); end
      n_vec++; if (shift_cnt !== 3'((k + 1) % 4)) begin n_err++; $display("FAIL shl_cnt[%0d] got=%0d exp=%0d", k, shift_cnt, (k + 1) % 4); end
      n_vec++; if (frame_done !== (k == 3)) begin n_err++; $display("FAIL shl_fd[%0d] got=%b exp=%b", k, frame_done, (k == 3)); end
    end
    n_vec++; if (qb !== 4'b0000) begin n_err++; $display("FAIL shl_qb_end got=%b exp=0000", qb); end
    mode = 2'b00;
    tick();
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL shl_fd_pulse_end got=%b exp=0", frame_done); end
    n_vec++; if (q !== 4'b1111) begin n_err++; $display("FAIL hold_q got=%b exp=1111", q); end
    n_vec++; if (so !== 1'b1) begin n_err++; $display("FAIL hold_so got=%b exp=1", so); end
  endtask

  task automatic test_reset_enable();
    logic [3:0] exp_q [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    mode = 2'b01; si = 1'b0;
    tick();
    tick();
    n_vec++; if (shift_cnt !== 3'd2) begin n_err++; $display("FAIL pre_rst_cnt got=%0d exp=2", shift_cnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_vec++; if (q !== 4'b0000) begin n_err++; $display("FAIL midrst_q got=%b exp=0000", q); end
    n_vec++; if (qb !== 4'b1111) begin n_err++; $display("FAIL midrst_qb got=%b exp=1111", qb); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL midrst_cnt got=%0d exp=0", shift_cnt); end
    en = 1'b0; si = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (q !== 4'b0000) begin n_err++; $display("FAIL en0_q[%0d] got=%b exp=0000", k, q); end
      n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL en0_cnt[%0d] got=%0d exp=0", k, shift_cnt); end
      n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL en0_fd[%0d] got=%b exp=0", k, frame_done); end
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (q !== exp_q[k]) begin n_err++; $display("FAIL en1_q[%0d] got=%b exp=%b", k, q, exp_q[k]); end
      n_vec++; if (frame_done !== (k == 3)) begin n_err++; $display("FAIL en1_fd[%0d] got=%b exp=%b", k, frame_done, (k == 3)); end
    end
  endtask

  task automatic test_rotate();
`ifdef USR_ROTATE_EN
    logic [3:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
`else
    logic [3:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b0000};
`endif
    mode = 2'b11; d = 4'b1000;
    tick();
    mode = 2'b01; rotate = 1'b1; si = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++; if (q !== exp_q[k]) begin n_err++; $display("FAIL rot_q[%0d] got=%b exp=%b", k, q, exp_q[k]); end
      n_vec++; if (frame_done !== (k == 3)) begin n_err++; $display("FAIL rot_fd[%0d] got=%b exp=%b", k, frame_done, (k == 3)); end
    end
    rotate = 1'b0;
  endtask

  task automatic test_reload_midframe();
    mode = 2'b10; si = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (shift_cnt !== 3'd3) begin n_err++; $display("FAIL reload_pre_cnt got=%0d exp=3", shift_cnt); end
    mode = 2'b11; d = 4'b0110;
    tick();
    n_vec++; if (q !== 4'b0110) begin n_err++; $display("FAIL reload_q got=%b exp=0110", q); end
    n_vec++; if (shift_cnt !== 3'd0) begin n_err++; $display("FAIL reload_cnt got=%0d exp=0", shift_cnt); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reload_fd got=%b exp=0", frame_done); end
    mode = 2'b01; si = 1'b0;
    tick();
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reload_next_fd got=%b exp=0", frame_done); end
    n_vec++; if (shift_cnt !== 3'd1) begin n_err++; $display("FAIL reload_next_cnt got=%0d exp=1", shift_cnt); end
    n_vec++; if (q !== 4'b0011) begin n_err++; $display("FAIL reload_next_q got=%b exp=0011", q); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q;
    mode = 2'b11; d = 4'b0000;
    tick();
    exp_q = 4'b0000;
    mode = 2'b10;
    for (int k = 0; k < 8; k++) begin
      si = k[0] ^ k[2];
      exp_q = {exp_q[2:0], si};
      tick();
      n_vec++; if (q !== exp_q) begin n_err++; $display("FAIL b2b_q[%0d] got=%b exp=%b", k, q, exp_q); end
      n_vec++; if (frame_done !== ((k % 4) == 3)) begin n_err++; $display("FAIL b2b_fd[%0d] got=%b exp=%b", k, frame_done, ((k % 4) == 3)); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load();
    test_shift_right();
    test_shift_left();
    test_reset_enable();
    test_rotate();
    test_reload_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the 4-bit parallel-in/parallel-out register.
- WIDTH-bit universal register supporting hold, parallel load, shift right and shift left.
- Provides true and complement outputs, a serial output, and a shift-frame counter that flags each complete WIDTH-bit serialisation.
- Used as a SIPO/PISO/PIPO front end for serial links and for test-data staging.

Parameters:
- WIDTH, 4, register width in bits; minimum 2.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  clock enable; when 0, all state holds.
- mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- d  input  WIDTH  parallel load data.
- si  input  1  serial input bit.
- rotate  input  1  rotate request; used only with USR_ROTATE_EN defined.
- q  output  WIDTH  register contents.
- qb  output  WIDTH  bitwise complement of q, registered.
- so  output  1  serial output (combinational from q).
- shift_cnt  output  CNT_W  number of shifts since the last load or frame wrap.
- frame_done  output  1  one-cycle pulse marking a completed frame.

Behaviour:
- Interface (decided): one clock, clk; reset rst_n is synchronous and active-low. Nothing is asynchronous.
- Reset (rst_n=0 at a rising edge), regardless of en or mode:
  - q=0, qb=all ones.
  - shift_cnt=0, frame_done=0.
  - Reset asserted mid-frame discards the partial frame.
- en=0: q, qb and shift_cnt hold; frame_done=0 on the next edge.
- en=1, mode=00 (hold): q and shift_cnt hold; frame_done=0.
- en=1, mode=11 (load): q<=d, shift_cnt<=0, frame_done<=0.
- en=1, mode=01 (shift right): q<={si, q[WIDTH-1:1]}.
- en=1, mode=10 (shift left): q<={q[WIDTH-2:0], si}.
- qb is always ~q, updated on the same edge. It is never an independent state.
- Counter, on each shift:
  - If shift_cnt==WIDTH-1: shift_cnt<=0 and frame_done<=1 for exactly one cycle.
  - Otherwise: shift_cnt<=shift_cnt+1 and frame_done<=0.
  - frame_done is therefore asserted in the cycle after the WIDTH-th shift.
- so = q[0] when mode==01, else q[WIDTH-1]. It shows the bit that the next edge shifts out.
- Latency: one clock from input sample to q/qb/shift_cnt/frame_done update.
- Back-to-back frames: continuous shifting gives a frame_done pulse every WIDTH shifts with no gap cycles.
- mode may change on any cycle. A load mid-frame restarts counting from 0.

Optional Feature:
- Macro: USR_ROTATE_EN.
- Defined, rotate=1 during a shift: the fill bit is the bit shifted out, not si.
  - Right: q<={q[0], q[WIDTH-1:1]}.
  - Left: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - Counter and frame_done behave exactly as for a normal shift.
- Not defined: rotate is ignored and si is always the fill bit.

Decomposition:
- Shared package usr_pkg holds:
  - typedef usr_mode_t (2-bit enum: USR_HOLD, USR_SHR, USR_SHL, USR_LOAD).
  - Constant USR_MODE_W=2.
- Natural sub-module: usr_cell, one flop with a 4:1 next-state mux (hold/left neighbour/right neighbour/d) driving q and qb.
  - Instantiated WIDTH times in a generate loop.
  - The counter and frame_done logic stay in the top module.

Test Plan (WIDTH=4):
- Load: rst_n=1, en=1, mode=11, d=4'b1011 -> q=1011, qb=0100, shift_cnt=0, frame_done=0.
- Shift right: from q=1011, mode=01, si=0, 4 cycles.
  - so before each edge: 1,1,0,1.
  - q: 0101, 0010, 0001, 0000.
  - shift_cnt: 1, 2, 3, 0; frame_done=1 only after the 4th edge.
- Shift left: from q=0000, mode=10, si=1, 4 cycles -> q: 0001, 0011, 0111, 1111; frame_done pulses once; qb ends 0000.
- Reset and enable: after 2 right shifts (shift_cnt=2), drive rst_n=0 for one edge.
  - q=0000, qb=1111, shift_cnt=0.
  - Then en=0 with mode=01 for 3 cycles: no change.
  - Then en=1: frame_done only after 4 further shifts.
- Rotate (USR_ROTATE_EN defined): load 1000, mode=01, rotate=1, si=0 -> q: 0100, 0010, 0001, 1000; frame_done after the 4th. Same stimulus without the macro -> q ends 0000.
- Reload mid-frame: after 3 shifts, mode=11, d=0110 -> q=0110, shift_cnt=0, no frame_done pulse.
